data_sram_like_responder: RTL and testbench
===========================================

Name: data_sram_like_responder

Overview:
- Responder end of the data-side SRAM-like request interface driven by the EXE stage: req/wr/size/addr/wdata with addr_ok handshake, plus the MEM-side data_ok/rdata return.
- Backs requests with an internal word-addressed memory array.
- Queues up to OUTSTANDING accepted requests and returns their responses in order after a programmable latency.
- Serves as the standalone bench responder for CPU data-path verification and as a drop-in local data RAM.

Parameters:
- MEM_AW, 10: word-address width; array holds 2^MEM_AW 32-bit words; addr[MEM_AW+1:2] indexes it, upper bits are ignored (address aliases).
- OUTSTANDING, 2: response queue depth, legal 1..4.
- DATA_LATENCY, 2: minimum cycles from acceptance to data_ok, legal 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_req  in  1  request valid
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = halfword, 2 = word/unaligned-partial
- data_addr  in  32  byte address
- data_wdata  in  32  lane-aligned write data
- data_addr_ok  out  1  request accepted this cycle when high together with data_req
- data_rdata  out  32  read data, valid only while data_ok = 1
- data_ok  out  1  one-cycle response pulse; one pulse per accepted request, reads and writes
- outstanding_cnt  out  3  number of accepted requests not yet responded

Behaviour:
- Reset: data_addr_ok = 0, data_ok = 0, data_rdata = 0, outstanding_cnt = 0, queue emptied. Memory contents are not reset.
- Reset mid-operation discards all in-flight entries; no data_ok is produced for them.
- Acceptance:
  - data_addr_ok = !full (combinational from registered queue state; not dependent on data_req).
  - A request is accepted when data_req && data_addr_ok.
  - When full, a same-cycle pop does not raise addr_ok; there is no bypass.
- Write strobes from data_size and addr[1:0]:
  - size 0: 0001 << a.
  - size 1: a = 0 or 1 -> 0011; a = 2 or 3 -> 1100.
  - size 2: a = 0 -> 1111; a = 1 -> 1110; a = 2 -> 0111; a = 3 -> 1111.
  - size 3: no bytes written; the request is still accepted and still answered.
- Writes update the array at the acceptance clock edge, enabled bytes only.
- Reads capture the whole 32-bit word at acceptance, after any write accepted in an earlier cycle. This gives strict program-order consistency.
- rdata is the full word; lane extraction is the requester's job.
- Queue:
  - Circular buffer of OUTSTANDING entries {wr, rdata, age}.
  - Head and tail pointers wrap modulo OUTSTANDING.
  - Each entry's age starts at 0 at acceptance, increments every cycle, and saturates at DATA_LATENCY.
- Response:
  - data_ok is registered. It pulses when the head entry has age == DATA_LATENCY, and the head is popped in that same cycle.
  - data_rdata = head rdata for reads and 0 for writes.
  - Consecutive data_ok pulses may occur on back-to-back cycles.
- Latency: with an empty queue, a request accepted at cycle T gives data_ok at cycle T + DATA_LATENCY.
- Push and pop in the same cycle: outstanding_cnt is unchanged.
- full = (cnt == OUTSTANDING); empty = (cnt == 0).
- Protocol check (simulation only): $error if data_req falls, or addr/wr/size/wdata change, while data_req is high and addr_ok is low.

Optional Feature:
- Macro: DATA_ADDR_OK_STALL_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle.
  - data_addr_ok = !full && !lfsr[0].
  - This stresses the EXE-stage wait-for-addr_ok state.
- Undefined: no LFSR is instantiated, and addr_ok = !full.

Test Plan:
- Reset, then sw of 32'h12345678 at 0x100 (size 2), then lw from 0x100 -> addr_ok high on the request cycle; write data_ok at T+2 with rdata 0; read data_ok at T'+2 with rdata 32'h12345678.
- sb of 32'hAAAAAAAA at 0x101, then sh of 32'hBBBBBBBB at 0x102, then lw from 0x100 -> rdata 32'hBBBBAA78 (strobes 0010, then 1100).
- swl at 0x102 (size 2, wdata 32'h00AABBCC) over 32'h11223344, then lw -> strobes 0111; rdata 32'h11AABBCC.
- Assert data_req every cycle with reads, DATA_LATENCY = 3, OUTSTANDING = 2 -> addr_ok low once 2 requests are outstanding; outstanding_cnt never exceeds 2; data_ok returns in order with the correct per-address data.
- Reset asserted with 2 requests outstanding -> no data_ok afterwards; cnt = 0; addr_ok high the cycle after reset releases; memory still holds the earlier writes.
- With DATA_ADDR_OK_STALL_EN defined, 100 random requests -> all 100 answered in order with no lost or duplicated data_ok; addr_ok deasserted in at least one cycle while not full.

Source files
------------

// File: rtl/data_sram_like_responder_if.sv
// Data-side SRAM-like request/response bundle between the EXE/MEM stages (master)
// and a memory responder (slave).
interface data_sram_like_responder_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_rdata, data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_rdata, data_ok
    );
endinterface

// File: rtl/data_sram_like_responder.sv
// Data-side SRAM-like responder: word-addressed local RAM, in-order response queue with fixed
// latency. Define DATA_ADDR_OK_STALL_EN to add LFSR-driven pseudo-random addr_ok stalls.
module data_sram_like_responder #(
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned DATA_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    data_sram_like_responder_if.slave    bus,
    output logic [2:0]                   outstanding_cnt
);

    localparam int unsigned Slots   = 4;
    localparam logic [2:0]  Depth   = 3'(OUTSTANDING);
    localparam logic [2:0]  Lat     = 3'(DATA_LATENCY);
    localparam logic [1:0]  LastPtr = 2'(OUTSTANDING - 1);

    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] word_idx;
    logic [31:0]       mem_word;
    logic [3:0]        strb;

    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic        ent_wr_q    [Slots];
    logic [31:0] ent_rdata_q [Slots];
    logic [2:0]  ent_age_q   [Slots];

    logic        data_ok_q;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic full, addr_ok, accept, push, head_fire, new_fire;
    logic unused_addr_bits;

    assign full = (cnt_q == Depth);

`ifdef DATA_ADDR_OK_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign addr_ok = !reset && !full && !lfsr_q[0];
`else
    assign addr_ok = !reset && !full;
`endif

    assign bus.data_addr_ok = addr_ok;
    assign accept           = bus.data_req && addr_ok;

    assign word_idx         = bus.data_addr[MEM_AW+1:2];
    assign mem_word         = mem[word_idx];
    assign unused_addr_bits = ^bus.data_addr[31:MEM_AW+2];

    always_comb begin
        strb = 4'b0000;
        unique case (bus.data_size)
            2'd0: strb = 4'b0001 << bus.data_addr[1:0];
            2'd1: strb = bus.data_addr[1] ? 4'b1100 : 4'b0011;
            2'd2: begin
                unique case (bus.data_addr[1:0])
                    2'd1:    strb = 4'b1110;
                    2'd2:    strb = 4'b0111;
                    default: strb = 4'b1111;
                endcase
            end
            default: strb = 4'b0000;
        endcase
    end

    // Writes land at the acceptance edge, so any later read sees them.
    always_ff @(posedge clk) begin
        if (accept && bus.data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stored age counts cycles since acceptance; the head fires on the edge where it reaches
    // Lat, so the registered data_ok lands exactly Lat cycles after the accept cycle.
    assign head_fire = (cnt_q != 3'd0) && (ent_age_q[head_q] >= Lat - 3'd1);
    // With a one-cycle latency a request goes straight to the response register.
    assign new_fire  = accept && (cnt_q == 3'd0) && (Lat == 3'd1);
    assign push      = accept && !new_fire;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            tail_d = (tail_q == LastPtr) ? 2'd0 : tail_q + 2'd1;
        end
        if (head_fire) begin
            head_d = (head_q == LastPtr) ? 2'd0 : head_q + 2'd1;
        end
        case ({push, head_fire})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        data_rdata_d = 32'h0;
        if (head_fire) begin
            data_rdata_d = ent_wr_q[head_q] ? 32'h0 : ent_rdata_q[head_q];
        end else if (new_fire) begin
            data_rdata_d = bus.data_wr ? 32'h0 : mem_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 3'd0;
            head_q       <= 2'd0;
            tail_q       <= 2'd0;
            data_ok_q    <= 1'b0;
            data_rdata_q <= 32'h0;
            for (int i = 0; i < Slots; i++) begin
                ent_age_q[i] <= 3'd0;
            end
        end else begin
            cnt_q        <= cnt_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            data_ok_q    <= head_fire || new_fire;
            data_rdata_q <= data_rdata_d;
            for (int i = 0; i < Slots; i++) begin
                if (ent_age_q[i] < Lat) begin
                    ent_age_q[i] <= ent_age_q[i] + 3'd1;
                end
            end
            if (push) begin
                ent_wr_q[tail_q]    <= bus.data_wr;
                ent_rdata_q[tail_q] <= bus.data_wr ? 32'h0 : mem_word;
                ent_age_q[tail_q]   <= 3'd1;
            end
        end
    end

    assign bus.data_ok    = data_ok_q;
    assign bus.data_rdata = data_rdata_q;
    assign outstanding_cnt = cnt_q;

`ifndef SYNTHESIS
    logic        chk_hold_q;
    logic        chk_wr_q;
    logic [1:0]  chk_size_q;
    logic [31:0] chk_addr_q, chk_wdata_q;

    // A stalled request must be held unchanged until it is accepted.
    always_ff @(posedge clk) begin
        chk_hold_q  <= !reset && bus.data_req && !addr_ok;
        chk_wr_q    <= bus.data_wr;
        chk_size_q  <= bus.data_size;
        chk_addr_q  <= bus.data_addr;
        chk_wdata_q <= bus.data_wdata;
        if (!reset && chk_hold_q &&
            (!bus.data_req || bus.data_wr != chk_wr_q || bus.data_size != chk_size_q ||
             bus.data_addr != chk_addr_q || bus.data_wdata != chk_wdata_q)) begin
            $error("data request dropped or changed while waiting for addr_ok");
        end
    end
`endif

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Randomised self-checking bench for data_sram_like_responder against a cycle-level
// transaction model (each accepted request is answered exactly Lat cycles later, in order).
module tb_data_sram_like_responder;

    localparam int unsigned Lat   = 3;
    localparam int unsigned Depth = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] outstanding_cnt;

    data_sram_like_responder_if bus();

    data_sram_like_responder #(
        .MEM_AW      (10),
        .OUTSTANDING (Depth),
        .DATA_LATENCY(Lat)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .outstanding_cnt(outstanding_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] model_mem [1024];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned model_cnt = 0;
    int unsigned dut_ok_cnt = 0;
    int unsigned max_cnt = 0;
    int unsigned full_stall = 0;
    int unsigned free_stall = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] lanes(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'(1 << a);
            2'd1:    return (a < 2) ? 4'b0011 : 4'b1100;
            2'd2:    return (a == 2'd1) ? 4'b1110 : (a == 2'd2) ? 4'b0111 : 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transaction-level monitor and reference model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            logic        exp_ok;
            logic [3:0]  ln;
            int unsigned idx;
            exp_ok = (rq.size() > 0) && (rq[0].due == cyc);
            if (bus.data_ok === 1'b1) dut_ok_cnt++;
            check("data_ok", 32'(bus.data_ok), 32'(exp_ok));
            if (exp_ok) begin
                check("rdata", bus.data_rdata, rq[0].data);
                last_rdata = bus.data_rdata;
                void'(rq.pop_front());
                model_cnt--;
            end
            check("outstanding_cnt", 32'(outstanding_cnt), model_cnt);
            if (32'(outstanding_cnt) > max_cnt) max_cnt = 32'(outstanding_cnt);
`ifdef DATA_ADDR_OK_STALL_EN
            if (bus.data_addr_ok) check("addr_ok_only_when_free", 32'(model_cnt < Depth), 32'd1);
            if (!bus.data_addr_ok && !reset && model_cnt < Depth) free_stall++;
`else
            check("addr_ok", 32'(bus.data_addr_ok), 32'(!reset && model_cnt < Depth));
`endif
            if (bus.data_req && !bus.data_addr_ok && model_cnt == Depth) full_stall++;
            if (reset) begin
                rq.delete();
                model_cnt = 0;
            end else if (bus.data_req && bus.data_addr_ok) begin
                idx = 32'(bus.data_addr[11:2]);
                rq.push_back('{due: cyc + Lat,
                               data: bus.data_wr ? 32'h0 : model_mem[idx]});
                model_cnt++;
                if (bus.data_wr) begin
                    ln = lanes(bus.data_size, bus.data_addr[1:0]);
                    for (int b = 0; b < 4; b++)
                        if (ln[b]) model_mem[idx][8*b +: 8] = bus.data_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic idle(input int unsigned n);
        bus.data_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int unsigned waited = 0;
        logic ok;
        bus.data_req   = 1'b1;
        bus.data_wr    = wr;
        bus.data_size  = size;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
        forever begin
            @(negedge clk);
            ok = bus.data_addr_ok;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 40) begin
                check("accept_timeout", waited, 32'd0);
                break;
            end
        end
        bus.data_req = 1'b0;
    endtask

    initial begin
        int unsigned snap;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", bus.data_rdata, 32'h0);
        reset = 1'b0;
        #1;

        // sw / lw round trip
        issue(1'b1, 2'd2, 32'h100, 32'h12345678);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        idle(Lat + 2);
        check("lw_after_sw", last_rdata, 32'h12345678);

        // sb then sh into the same word
        issue(1'b1, 2'd0, 32'h101, 32'hAAAAAAAA);
        issue(1'b1, 2'd1, 32'h102, 32'hBBBBBBBB);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        idle(Lat + 2);
        check("lw_after_sb_sh", last_rdata, 32'hBBBBAA78);

        // partial word at offset 2, then a size-3 request that writes nothing
        issue(1'b1, 2'd2, 32'h104, 32'h11223344);
        issue(1'b1, 2'd2, 32'h106, 32'h00AABBCC);
        issue(1'b0, 2'd2, 32'h104, 32'h0);
        idle(Lat + 2);
        check("lw_after_swl", last_rdata, 32'h11AABBCC);
        issue(1'b1, 2'd3, 32'h104, 32'hFFFFFFFF);
        issue(1'b0, 2'd2, 32'h104, 32'h0);
        idle(Lat + 2);
        check("size3_no_write", last_rdata, 32'h11AABBCC);

        // back-to-back reads saturate the queue
        full_stall = 0;
        max_cnt = 0;
        for (int i = 0; i < 8; i++) issue(1'b0, 2'd2, (i % 2 == 0) ? 32'h100 : 32'h104, 32'h0);
        idle(Lat + 2);
        check("stream_full_stall_seen", 32'(full_stall > 0), 32'd1);
        check("stream_cnt_max", 32'(max_cnt <= Depth), 32'd1);
        check("stream_last_data", last_rdata, 32'h11AABBCC);

        // reset with two reads in flight
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        issue(1'b0, 2'd2, 32'h104, 32'h0);
        snap = dut_ok_cnt;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(Lat + 3);
        check("no_ok_after_reset", dut_ok_cnt - snap, 32'd0);
        check("cnt_after_reset", 32'(outstanding_cnt), 32'd0);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        idle(Lat + 2);
        check("mem_kept_over_reset", last_rdata, 32'hBBBBAA78);

        // fill a 16-word window so random reads only see known data
        for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'h200 + 32'(4 * i), $urandom);
        idle(Lat + 2);

        snap = dut_ok_cnt;
        free_stall = 0;
        for (int i = 0; i < 100; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  32'h200 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12),
                  $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(Lat + 4);
        check("random_all_answered", dut_ok_cnt - snap, 32'd100);
        check("random_queue_drained", 32'(rq.size()), 32'd0);
`ifdef DATA_ADDR_OK_STALL_EN
        check("random_stall_seen", 32'(free_stall > 0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
